// File: rtl/tensor_core_pkg.sv
// Shared types and sizing helpers for the tensor-core fetch path.
// The credit counter width is derived from the return-buffer depth.
package tensor_core_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W          = $clog2(FIFO_DEPTH_DEF + 1);

  // A counter that must reach `depth` inclusive needs clog2(depth+1) bits.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/char_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO holding read returns.
// Head is visible combinationally; a push into an empty FIFO appears the next cycle.
module char_fetch_fifo
  import tensor_core_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    // A push while full is only legal when a pop frees the slot in the same cycle.
    do_push = push && (!full || do_pop);

    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      ram[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = ram[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/char_fetch.sv
// Turns the incrementer's address stream into fixed-latency SRAM reads and buffers
// the returns in a credit-managed FIFO feeding the tensor core with valid/ready/last.
module char_fetch
  import tensor_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_last,
  output logic                  halt,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (FIFO_DEPTH == FIFO_DEPTH_DEF) ? CNT_W : cnt_width(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  fetch_state_t state_q, state_d;

  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic                  rd_last_q, rd_last_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  last_popped_q, last_popped_d;

  logic                  accept;
  logic                  credit_ok;
  logic [CW:0]           credit_used;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   fifo_rdata;

  // Credits cover every read from acceptance until its word leaves the FIFO,
  // so a return always finds a free slot and the pipe never has to stall.
  always_comb begin
    credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    credit_ok   = !fifo_full && (credit_used < DEPTH_C);
    accept      = in_valid && in_ready;
    fifo_push   = pipe_vld_q[RD_LATENCY-1];
    fifo_pop    = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0 && fifo_empty && last_popped_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FETCH) && credit_ok;
    halt      = !in_ready;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    out_valid = !fifo_empty;
    out_data  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH:1];
    out_last  = !fifo_empty && fifo_rdata[0];
  end

  always_comb begin
    mem_rd_en_d   = accept;
    mem_rd_addr_d = accept ? in_addr : mem_rd_addr_q;
    rd_last_d     = accept && in_last;

    // Stage 0 lines up with the cycle after mem_rd_en; the tail lines up with valid data.
    pipe_vld_d[0]  = mem_rd_en_q;
    pipe_last_d[0] = rd_last_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end

    inflight_d = inflight_q + CW'(accept) - CW'(fifo_push);

    last_popped_d = last_popped_q;
    if (state_q == IDLE) begin
      last_popped_d = 1'b0;
    end else if (fifo_pop && fifo_rdata[0]) begin
      last_popped_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      rd_last_q     <= 1'b0;
      pipe_vld_q    <= '0;
      pipe_last_q   <= '0;
      inflight_q    <= '0;
      last_popped_q <= 1'b0;
    end else begin
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      rd_last_q     <= rd_last_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_last_q   <= pipe_last_d;
      inflight_q    <= inflight_d;
      last_popped_q <= last_popped_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;

  char_fetch_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({mem_rd_data, pipe_last_q[RD_LATENCY-1]}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
